// File: rtl/spu_issue_sequencer.sv
// spu_issue_sequencer
//
// Dual-issue instruction sequencer for the SPU bench and self-test path.
// Instruction words are queued into an even-pipe FIFO and an odd-pipe FIFO.
// They are issued one pair per cycle as registered words. An empty slot is
// padded with NOP_EVEN / NOP_ODD. An optional gap of padding pairs can follow
// each issued pair. A taken branch squashes everything that is queued.
//
// Optional feature macro: SPU_ISSUE_PAIR_LOCK_EN
//   defined   : a pair issues only when both FIFOs hold a word; the slots pop together.
//   undefined : a pair issues when either FIFO holds a word; each slot pops on its own.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   wr_valid/wr_pipe    : enqueue request and target FIFO (0 = even, 1 = odd)
//   wr_instr            : word to enqueue
//   wr_ready            : combinational, !full[wr_pipe] && !branch_taken
//   issue_en            : allows issue; when low the sequencer drops to IDLE
//   gap_cycles          : padding pairs that follow each issued pair
//   branch_taken        : flush request from the odd pipe
//   even_instr/odd_instr: registered issue words
//   even_valid/odd_valid: registered; high only for a real popped word
//   even_count/odd_count: FIFO occupancy
//   issued_pairs        : cycles in which at least one real word issued
//   busy                : state is not IDLE

module spu_issue_sequencer #(
  parameter int                 INSTR_W       = 32,
  parameter int                 DEPTH         = 64,
  parameter int                 GAP_W         = 4,
  parameter int                 FLUSH_BUBBLES = 3,
  parameter logic [INSTR_W-1:0] NOP_EVEN      = 32'h4020_0000,
  parameter logic [INSTR_W-1:0] NOP_ODD       = 32'h0020_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic                     wr_pipe,
  input  logic [INSTR_W-1:0]       wr_instr,
  output logic                     wr_ready,
  input  logic                     issue_en,
  input  logic [GAP_W-1:0]         gap_cycles,
  input  logic                     branch_taken,
  output logic [INSTR_W-1:0]       even_instr,
  output logic [INSTR_W-1:0]       odd_instr,
  output logic                     even_valid,
  output logic                     odd_valid,
  output logic [$clog2(DEPTH):0]   even_count,
  output logic [$clog2(DEPTH):0]   odd_count,
  output logic [31:0]              issued_pairs,
  output logic                     busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int BUB_W = (FLUSH_BUBBLES < 1) ? 1 : $clog2(FLUSH_BUBBLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, FLUSH} state_t;

  state_t state, state_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic [BUB_W-1:0] bub_cnt, bub_next;
  logic go_issue;
  logic pop_even, pop_odd;

  logic [INSTR_W-1:0] even_mem [DEPTH];
  logic [INSTR_W-1:0] odd_mem  [DEPTH];
  logic [PW-1:0] even_wr_ptr, even_rd_ptr;
  logic [PW-1:0] odd_wr_ptr, odd_rd_ptr;
  logic even_empty, even_full, odd_empty, odd_full;
  logic wr_en, even_wr, odd_wr;
  logic issue_cond;

  // Pointers are one bit wider than the address. Equal pointers mean empty.
  // Differing MSBs with equal address bits mean full.
  assign even_empty = (even_wr_ptr == even_rd_ptr);
  assign odd_empty  = (odd_wr_ptr == odd_rd_ptr);
  assign even_full  = (even_wr_ptr[AW] != even_rd_ptr[AW]) &&
                      (even_wr_ptr[AW-1:0] == even_rd_ptr[AW-1:0]);
  assign odd_full   = (odd_wr_ptr[AW] != odd_rd_ptr[AW]) &&
                      (odd_wr_ptr[AW-1:0] == odd_rd_ptr[AW-1:0]);

  assign even_count = even_wr_ptr - even_rd_ptr;
  assign odd_count  = odd_wr_ptr - odd_rd_ptr;

  // Ready ignores any pop in the same cycle, so a full FIFO refuses writes
  // even while it is being drained.
  assign wr_ready = (wr_pipe ? !odd_full : !even_full) && !branch_taken;
  assign wr_en    = wr_valid && wr_ready;
  assign even_wr  = wr_en && !wr_pipe;
  assign odd_wr   = wr_en && wr_pipe;

`ifdef SPU_ISSUE_PAIR_LOCK_EN
  assign issue_cond = !even_empty && !odd_empty;
`else
  assign issue_cond = !even_empty || !odd_empty;
`endif

  // State and counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
      bub_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
      bub_cnt <= bub_next;
    end
  end

  // Next-state logic. go_issue marks an edge on which the state being entered
  // is ISSUE. The registered outputs then show the popped pair during that state.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    bub_next   = bub_cnt;
    go_issue   = 1'b0;
    if (branch_taken) begin
      state_next = FLUSH;
      bub_next   = BUB_W'(FLUSH_BUBBLES);
    end else begin
      case (state)
        IDLE: begin
          if (issue_en && issue_cond) begin
            state_next = ISSUE;
            go_issue   = 1'b1;
          end
        end
        ISSUE: begin
          if (!issue_en) begin
            state_next = IDLE;
          end else if (gap_cycles != '0) begin
            state_next = GAP;
            gap_next   = gap_cycles;
          end else if (issue_cond) begin
            state_next = ISSUE;
            go_issue   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        GAP: begin
          if (!issue_en) begin
            state_next = IDLE;
          end else if (gap_cnt <= GAP_W'(1)) begin
            gap_next = '0;
            if (issue_cond) begin
              state_next = ISSUE;
              go_issue   = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            gap_next = gap_cnt - GAP_W'(1);
          end
        end
        FLUSH: begin
          if (bub_cnt <= BUB_W'(1)) begin
            state_next = IDLE;
            bub_next   = '0;
          end else begin
            bub_next = bub_cnt - BUB_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: which slots pop on this edge, and the busy flag.
  always_comb begin
    pop_even = 1'b0;
    pop_odd  = 1'b0;
    if (go_issue) begin
`ifdef SPU_ISSUE_PAIR_LOCK_EN
      pop_even = 1'b1;
      pop_odd  = 1'b1;
`else
      pop_even = !even_empty;
      pop_odd  = !odd_empty;
`endif
    end
    busy = (state != IDLE);
  end

  // FIFO storage. It has no reset: only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (even_wr) even_mem[even_wr_ptr[AW-1:0]] <= wr_instr;
    if (odd_wr)  odd_mem[odd_wr_ptr[AW-1:0]]   <= wr_instr;
  end

  // FIFO pointers. A taken branch clears both queues. It also drops any
  // concurrent write, because wr_ready is low during a branch.
  always_ff @(posedge clk) begin
    if (reset || branch_taken) begin
      even_wr_ptr <= '0;
      even_rd_ptr <= '0;
      odd_wr_ptr  <= '0;
      odd_rd_ptr  <= '0;
    end else begin
      if (even_wr)  even_wr_ptr <= even_wr_ptr + PW'(1);
      if (odd_wr)   odd_wr_ptr  <= odd_wr_ptr + PW'(1);
      if (pop_even) even_rd_ptr <= even_rd_ptr + PW'(1);
      if (pop_odd)  odd_rd_ptr  <= odd_rd_ptr + PW'(1);
    end
  end

  // Registered issue words and the issue counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      even_instr   <= NOP_EVEN;
      odd_instr    <= NOP_ODD;
      even_valid   <= 1'b0;
      odd_valid    <= 1'b0;
      issued_pairs <= '0;
    end else begin
      even_instr <= pop_even ? even_mem[even_rd_ptr[AW-1:0]] : NOP_EVEN;
      odd_instr  <= pop_odd  ? odd_mem[odd_rd_ptr[AW-1:0]]   : NOP_ODD;
      even_valid <= pop_even;
      odd_valid  <= pop_odd;
      if (pop_even || pop_odd) issued_pairs <= issued_pairs + 32'd1;
    end
  end

endmodule

// File: tb/tb_spu_issue_sequencer.sv
// Testbench for spu_issue_sequencer (default DEPTH=64, GAP_W=4, FLUSH_BUBBLES=3).
// Most scenarios are per-cycle vector tables. Deep-FIFO wrap and lone-word
// behaviour are hand-written sequences.

module tb_spu_issue_sequencer;

  localparam logic [31:0] NE = 32'h4020_0000;
  localparam logic [31:0] NO = 32'h0020_0000;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_pipe;
  logic [31:0] wr_instr;
  logic        wr_ready;
  logic        issue_en;
  logic [3:0]  gap_cycles;
  logic        branch_taken;
  logic [31:0] even_instr, odd_instr;
  logic        even_valid, odd_valid;
  logic [6:0]  even_count, odd_count;
  logic [31:0] issued_pairs;
  logic        busy;

  int errors = 0;
  int checks = 0;

  spu_issue_sequencer dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_pipe(wr_pipe), .wr_instr(wr_instr), .wr_ready(wr_ready),
    .issue_en(issue_en), .gap_cycles(gap_cycles), .branch_taken(branch_taken),
    .even_instr(even_instr), .odd_instr(odd_instr),
    .even_valid(even_valid), .odd_valid(odd_valid),
    .even_count(even_count), .odd_count(odd_count),
    .issued_pairs(issued_pairs), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        wv;
    logic        wp;
    logic [31:0] wd;
    logic        ie;
    logic [3:0]  gap;
    logic        br;
    logic        rdy;
    logic [31:0] ee;
    logic        ev;
    logic [31:0] eo;
    logic        ov;
    logic [6:0]  ec;
    logic [6:0]  oc;
    logic        bsy;
    logic [31:0] pairs;
  } vec_t;

  vec_t vq[$];

  // None of the table scenarios fills a FIFO, so ready is low only during a branch.
  function automatic vec_t mk(logic rst, logic wv, logic wp, logic [31:0] wd,
                              logic ie, logic [3:0] gap, logic br,
                              logic [31:0] ee, logic ev, logic [31:0] eo, logic ov,
                              int ec, int oc, logic bsy, int pairs);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wp = wp; v.wd = wd; v.ie = ie; v.gap = gap; v.br = br;
    v.rdy = !br;
    v.ee = ee; v.ev = ev; v.eo = eo; v.ov = ov;
    v.ec = 7'(ec); v.oc = 7'(oc); v.bsy = bsy; v.pairs = 32'(pairs);
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkValue($sformatf("v%0d.even_instr", idx), even_instr, v.ee);
    checkValue($sformatf("v%0d.even_valid", idx), 32'(even_valid), 32'(v.ev));
    checkValue($sformatf("v%0d.odd_instr", idx), odd_instr, v.eo);
    checkValue($sformatf("v%0d.odd_valid", idx), 32'(odd_valid), 32'(v.ov));
    checkValue($sformatf("v%0d.even_count", idx), 32'(even_count), 32'(v.ec));
    checkValue($sformatf("v%0d.odd_count", idx), 32'(odd_count), 32'(v.oc));
    checkValue($sformatf("v%0d.busy", idx), 32'(busy), 32'(v.bsy));
    checkValue($sformatf("v%0d.issued_pairs", idx), issued_pairs, v.pairs);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    reset = v.rst; wr_valid = v.wv; wr_pipe = v.wp; wr_instr = v.wd;
    issue_en = v.ie; gap_cycles = v.gap; branch_taken = v.br;
    #1;
    checkValue($sformatf("v%0d.wr_ready", idx), 32'(wr_ready), 32'(v.rdy));
    @(posedge clk); #1;
    checkOutput(v, idx);
  endtask

  task automatic applyReset();
    reset = 1'b1; wr_valid = 1'b0; wr_pipe = 1'b0; wr_instr = '0;
    issue_en = 1'b0; gap_cycles = '0; branch_taken = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic writeWord(input logic p, input logic [31:0] d);
    wr_valid = 1'b1; wr_pipe = p; wr_instr = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  function automatic logic [31:0] ew(int i); return 32'hA000_0000 + 32'(i); endfunction
  function automatic logic [31:0] ow(int i); return 32'h0B00_0000 + 32'(i); endfunction

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_pipe = 1'b0; wr_instr = '0;
    issue_en = 1'b0; gap_cycles = '0; branch_taken = 1'b0;

    // Four pairs issued back to back with no gap.
    vq.push_back(mk(1,0,0,0, 0,0,0, NE,0,NO,0, 0,0,0,0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0,1,0,32'hE000_0000+32'(i), 0,0,0, NE,0,NO,0, i+1,0,0,0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0,1,1,32'h0D00_0000+32'(i), 0,0,0, NE,0,NO,0, 4,i+1,0,0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0,0,0,0, 1,0,0, 32'hE000_0000+32'(i),1,32'h0D00_0000+32'(i),1, 3-i,3-i,1,i+1));
    vq.push_back(mk(0,0,0,0, 1,0,0, NE,0,NO,0, 0,0,0,4));

    // Gap of 2: pair, pad, pad, pair, pad, pad, then IDLE.
    vq.push_back(mk(1,0,0,0, 0,2,0, NE,0,NO,0, 0,0,0,0));
    vq.push_back(mk(0,1,0,32'hE100_0000, 0,2,0, NE,0,NO,0, 1,0,0,0));
    vq.push_back(mk(0,1,1,32'h0D10_0000, 0,2,0, NE,0,NO,0, 1,1,0,0));
    vq.push_back(mk(0,1,0,32'hE100_0001, 0,2,0, NE,0,NO,0, 2,1,0,0));
    vq.push_back(mk(0,1,1,32'h0D10_0001, 0,2,0, NE,0,NO,0, 2,2,0,0));
    vq.push_back(mk(0,0,0,0, 1,2,0, 32'hE100_0000,1,32'h0D10_0000,1, 1,1,1,1));
    vq.push_back(mk(0,0,0,0, 1,2,0, NE,0,NO,0, 1,1,1,1));
    vq.push_back(mk(0,0,0,0, 1,2,0, NE,0,NO,0, 1,1,1,1));
    vq.push_back(mk(0,0,0,0, 1,2,0, 32'hE100_0001,1,32'h0D10_0001,1, 0,0,1,2));
    vq.push_back(mk(0,0,0,0, 1,2,0, NE,0,NO,0, 0,0,1,2));
    vq.push_back(mk(0,0,0,0, 1,2,0, NE,0,NO,0, 0,0,1,2));
    vq.push_back(mk(0,0,0,0, 1,2,0, NE,0,NO,0, 0,0,0,2));

    // Branch during ISSUE with 10 words queued and a concurrent write.
    vq.push_back(mk(1,0,0,0, 0,0,0, NE,0,NO,0, 0,0,0,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0,1,0,32'hE200_0000+32'(i), 0,0,0, NE,0,NO,0, i+1,0,0,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0,1,1,32'h0D20_0000+32'(i), 0,0,0, NE,0,NO,0, 5,i+1,0,0));
    vq.push_back(mk(0,0,0,0, 1,0,0, 32'hE200_0000,1,32'h0D20_0000,1, 4,4,1,1));
    vq.push_back(mk(0,1,0,32'hDEAD_BEEF, 1,0,1, NE,0,NO,0, 0,0,1,1));
    vq.push_back(mk(0,0,0,0, 1,0,0, NE,0,NO,0, 0,0,1,1));
    vq.push_back(mk(0,0,0,0, 1,0,0, NE,0,NO,0, 0,0,1,1));
    vq.push_back(mk(0,0,0,0, 1,0,0, NE,0,NO,0, 0,0,0,1));
    vq.push_back(mk(0,0,0,0, 1,0,0, NE,0,NO,0, 0,0,0,1));

    // Reset asserted in the middle of a gap with words still queued.
    vq.push_back(mk(1,0,0,0, 0,3,0, NE,0,NO,0, 0,0,0,0));
    for (int i = 0; i < 3; i++) begin
      vq.push_back(mk(0,1,0,32'hE300_0000+32'(i), 0,3,0, NE,0,NO,0, i+1,i,0,0));
      vq.push_back(mk(0,1,1,32'h0D30_0000+32'(i), 0,3,0, NE,0,NO,0, i+1,i+1,0,0));
    end
    vq.push_back(mk(0,0,0,0, 1,3,0, 32'hE300_0000,1,32'h0D30_0000,1, 2,2,1,1));
    vq.push_back(mk(0,0,0,0, 1,3,0, NE,0,NO,0, 2,2,1,1));
    vq.push_back(mk(0,0,0,0, 1,3,0, NE,0,NO,0, 2,2,1,1));
    vq.push_back(mk(1,0,0,0, 1,3,0, NE,0,NO,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,3,0, NE,0,NO,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0, 1,3,0, NE,0,NO,0, 0,0,0,0));

    for (int i = 0; i < vq.size(); i++) applyStimulus(vq[i], i);

    // Lone even words: issued alone, or held back when pair lock is enabled.
    applyReset();
    for (int i = 0; i < 3; i++) writeWord(1'b0, 32'hE400_0000 + 32'(i));
    issue_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
`ifdef SPU_ISSUE_PAIR_LOCK_EN
      checkValue($sformatf("lone%0d.even_valid", i), 32'(even_valid), 32'd0);
      checkValue($sformatf("lone%0d.busy", i), 32'(busy), 32'd0);
      checkValue($sformatf("lone%0d.even_count", i), 32'(even_count), 32'd3);
`else
      checkValue($sformatf("lone%0d.even_valid", i), 32'(even_valid), (i < 3) ? 32'd1 : 32'd0);
      checkValue($sformatf("lone%0d.even_instr", i), even_instr, (i < 3) ? 32'hE400_0000 + 32'(i) : NE);
      checkValue($sformatf("lone%0d.busy", i), 32'(busy), (i < 3) ? 32'd1 : 32'd0);
`endif
      checkValue($sformatf("lone%0d.odd_instr", i), odd_instr, NO);
      checkValue($sformatf("lone%0d.odd_valid", i), 32'(odd_valid), 32'd0);
    end
    issue_en = 1'b0;

    // Full FIFO, single pair issue, then two full drains so the pointers wrap.
    applyReset();
    for (int i = 0; i < 64; i++) writeWord(1'b0, ew(i));
    checkValue("full.even_count", 32'(even_count), 32'd64);
    wr_pipe = 1'b0; #1;
    checkValue("full.ready_even", 32'(wr_ready), 32'd0);
    wr_pipe = 1'b1; #1;
    checkValue("full.ready_odd", 32'(wr_ready), 32'd1);
    writeWord(1'b1, ow(0));
    issue_en = 1'b1;
    @(posedge clk); #1;
    issue_en = 1'b0;
    checkValue("one.even_instr", even_instr, ew(0));
    checkValue("one.odd_instr", odd_instr, ow(0));
    checkValue("one.even_count", 32'(even_count), 32'd63);
    writeWord(1'b0, ew(64));
    checkValue("refill.even_count", 32'(even_count), 32'd64);
    checkValue("refill.busy", 32'(busy), 32'd0);
    for (int r = 0; r < 2; r++) begin
      if (r == 1) for (int i = 65; i <= 128; i++) writeWord(1'b0, ew(i));
      for (int i = 1; i <= 64; i++) writeWord(1'b1, ow(i + 64*r));
      issue_en = 1'b1;
      for (int k = 1; k <= 64; k++) begin
        @(posedge clk); #1;
        checkValue($sformatf("drain%0d.even_instr", k + 64*r), even_instr, ew(k + 64*r));
        checkValue($sformatf("drain%0d.odd_instr", k + 64*r), odd_instr, ow(k + 64*r));
        checkValue($sformatf("drain%0d.even_count", k + 64*r), 32'(even_count), 32'(64 - k));
      end
      issue_en = 1'b0;
      @(posedge clk); #1;
      checkValue($sformatf("drain_end%0d.busy", r), 32'(busy), 32'd0);
    end
    checkValue("wrap.issued_pairs", issued_pairs, 32'd129);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
